// File: rtl/hpdmc_dly_seq.sv
// IODELAY2 tap-control sequencer: expands tap commands into spaced strobes.
// Optional HPDMC_DLY_SEQ_AUTOCAL_EN runs CAL then RST after reset.
module hpdmc_dly_seq #(
  parameter int TAP_W    = 8,
  parameter int TAP_MAX  = 255,
  parameter int GAP      = 4,
  parameter int CAL_WAIT = 32
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [5:0]       cmd_count,
  output logic             idelay_rst,
  output logic             idelay_cal,
  output logic             idelay_ce,
  output logic             idelay_inc,
  output logic [TAP_W-1:0] tap,
  output logic             sat,
  output logic             done
);

  localparam int WMAX = (GAP > CAL_WAIT) ? GAP : CAL_WAIT;
  localparam int WW   = $clog2(WMAX + 1);

  typedef enum logic [1:0] {
    S_IDLE, S_STROBE, S_GAP, S_CALW
  } state_t;

  typedef enum logic [1:0] {
    OP_RST, OP_CAL, OP_INC, OP_DEC
  } op_t;

  state_t           state, state_n;
  op_t              op, start_op;
  logic [5:0]       steps, start_steps;
  logic [WW-1:0]    wcnt;
  logic [TAP_W-1:0] tap_q;
  logic             sat_q, zdone;
  logic             start, zero, accept;
  logic             wz, step_ok, is_step;
  logic             auto_cal, auto_rst;

`ifdef HPDMC_DLY_SEQ_AUTOCAL_EN
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      auto_cal <= 1'b1;
      auto_rst <= 1'b1;
    end else begin
      if (state == S_IDLE) auto_cal <= 1'b0;
      if (state == S_CALW && wz) auto_rst <= 1'b0;
    end
  end
`else
  assign auto_cal = 1'b0;
  assign auto_rst = 1'b0;
`endif

  assign wz        = (wcnt == '0);
  assign cmd_ready = (state == S_IDLE) && !auto_cal;
  assign accept    = cmd_valid && cmd_ready;
  assign is_step   = (op == OP_INC) || (op == OP_DEC);

  always_comb begin
    step_ok = 1'b1;
    if (op == OP_INC) step_ok = (tap_q < TAP_W'(TAP_MAX));
    if (op == OP_DEC) step_ok = (tap_q != '0);
  end

  // Strobes decode straight from state so an async reset kills them at once.
  assign idelay_rst = (state == S_STROBE) && (op == OP_RST);
  assign idelay_cal = (state == S_STROBE) && (op == OP_CAL);
  assign idelay_ce  = (state == S_STROBE) && is_step && step_ok;
  assign idelay_inc = (state != S_IDLE) && (op == OP_INC);
  assign tap        = tap_q;
  assign sat        = sat_q;

  always_comb begin
    done = zdone;
    if (state == S_GAP && wz && steps == '0 && op != OP_CAL)
      done = 1'b1;
    if (state == S_CALW && wz && !auto_rst)
      done = 1'b1;
  end

  always_comb begin
    state_n  = state;
    start    = 1'b0;
    start_op = op_t'(cmd_op);
    unique case (state)
      S_IDLE: begin
        if (auto_cal) begin
          start    = 1'b1;
          start_op = OP_CAL;
        end else if (accept) begin
          start = 1'b1;
        end
      end
      S_STROBE: state_n = S_GAP;
      S_GAP: begin
        if (wz) begin
          if (steps != '0)       state_n = S_STROBE;
          else if (op == OP_CAL) state_n = S_CALW;
          else                   state_n = S_IDLE;
        end
      end
      S_CALW: begin
        if (wz) begin
          if (auto_rst) begin
            start    = 1'b1;
            start_op = OP_RST;
          end else begin
            state_n = S_IDLE;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
    start_steps = cmd_count;
    if (start_op == OP_RST || start_op == OP_CAL)
      start_steps = 6'd1;
    zero = start && (start_steps == '0);
    if (start) state_n = zero ? S_IDLE : S_STROBE;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= S_IDLE;
    else            state <= state_n;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      op    <= OP_RST;
      steps <= '0;
      wcnt  <= '0;
      tap_q <= '0;
      sat_q <= 1'b0;
      zdone <= 1'b0;
    end else begin
      zdone <= zero;
      if (start) begin
        op    <= start_op;
        steps <= start_steps;
      end
      unique case (state)
        S_STROBE: begin
          steps <= steps - 6'd1;
          wcnt  <= WW'(GAP - 1);
          if (op == OP_RST) begin
            tap_q <= '0;
            sat_q <= 1'b0;
          end else if (is_step && !step_ok) begin
            sat_q <= 1'b1;
          end else if (op == OP_INC) begin
            tap_q <= tap_q + TAP_W'(1);
          end else if (op == OP_DEC) begin
            tap_q <= tap_q - TAP_W'(1);
          end
        end
        S_GAP: begin
          if (!wz)                wcnt <= wcnt - WW'(1);
          else if (steps == '0)   wcnt <= WW'(CAL_WAIT - 1);
        end
        S_CALW: if (!wz) wcnt <= wcnt - WW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hpdmc_dly_seq.sv
// Self-checking bench for hpdmc_dly_seq against a per-command timing model.
// Covers reset, INC/DEC/RST/CAL, saturation, back-pressure and mid-command reset.
module tb_hpdmc_dly_seq;

  localparam int TAP_W    = 8;
  localparam int TAP_MAX  = 255;
  localparam int GAP      = 4;
  localparam int CAL_WAIT = 32;
  localparam int PER      = 1 + GAP;

  logic             sys_clk = 1'b0;
  logic             sys_rst_n = 1'b0;
  logic             cmd_valid = 1'b0;
  logic [1:0]       cmd_op = '0;
  logic [5:0]       cmd_count = '0;
  logic             cmd_ready;
  logic             idelay_rst, idelay_cal, idelay_ce, idelay_inc;
  logic [TAP_W-1:0] tap;
  logic             sat, done;

  int checks = 0;
  int errors = 0;
  int mtap = 0;
  bit msat = 1'b0;

  hpdmc_dly_seq #(
    .TAP_W(TAP_W), .TAP_MAX(TAP_MAX),
    .GAP(GAP), .CAL_WAIT(CAL_WAIT)
  ) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_count(cmd_count),
    .idelay_rst(idelay_rst), .idelay_cal(idelay_cal),
    .idelay_ce(idelay_ce), .idelay_inc(idelay_inc),
    .tap(tap), .sat(sat), .done(done)
  );

  always #5 sys_clk = ~sys_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outs(input string tag, input bit rdy);
    chk({tag, "_rst"}, idelay_rst, 0);
    chk({tag, "_cal"}, idelay_cal, 0);
    chk({tag, "_ce"}, idelay_ce, 0);
    chk({tag, "_inc"}, idelay_inc, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_tap"}, tap, 0);
    chk({tag, "_sat"}, sat, 0);
    chk({tag, "_ready"}, cmd_ready, rdy);
  endtask

  // After reset release: either expect the autonomous CAL/RST, or silence.
  task automatic post_reset();
    int ncal, nrst, ndone, tcal, trst, tdone, act, n;
    ncal = 0; nrst = 0; ndone = 0;
    tcal = -1; trst = -1; tdone = -1; act = 0; n = 0;
`ifdef HPDMC_DLY_SEQ_AUTOCAL_EN
    while (cmd_ready !== 1'b1 && n < 300) begin
      if (idelay_cal) begin ncal++; tcal = n; end
      if (idelay_rst) begin nrst++; trst = n; end
      if (done) begin ndone++; tdone = n; end
      if (idelay_ce) act++;
      @(negedge sys_clk);
      n++;
    end
    chk("auto_ready", cmd_ready, 1);
    chk("auto_ncal", ncal, 1);
    chk("auto_nrst", nrst, 1);
    chk("auto_ndone", ndone, 1);
    chk("auto_cal2rst", trst - tcal, 1 + GAP + CAL_WAIT);
    chk("auto_rst2done", tdone - trst, GAP);
    chk("auto_ready_after_done", n - tdone, 1);
    chk("auto_no_ce", act, 0);
    chk("auto_tap", tap, 0);
`else
    repeat (100) begin
      if (idelay_cal || idelay_rst || idelay_ce || done || !cmd_ready)
        act++;
      @(negedge sys_clk);
    end
    chk("idle100_activity", act, 0);
    chk_idle_outs("post_reset", 1'b1);
`endif
  endtask

  task automatic do_reset();
    sys_rst_n = 1'b0;
    cmd_valid = 1'b0;
    mtap = 0;
    msat = 1'b0;
    repeat (3) @(negedge sys_clk);
`ifdef HPDMC_DLY_SEQ_AUTOCAL_EN
    chk_idle_outs("in_reset", 1'b0);
`else
    chk_idle_outs("in_reset", 1'b1);
`endif
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
    post_reset();
  endtask

  // op: 0 RST, 1 CAL, 2 INC, 3 DEC. bp keeps cmd_valid high while busy.
  // abort_at > 0 asserts reset during that cycle after acceptance.
  task automatic run_cmd(input int op, input int n,
                         input bit bp, input int abort_at);
    int d, total, w;
    bit slot, can;
    w = 0;
    while (cmd_ready !== 1'b1 && w < 500) begin
      @(negedge sys_clk);
      w++;
    end
    chk("wait_ready", cmd_ready, 1);
    cmd_op = 2'(op);
    cmd_count = 6'(n);
    cmd_valid = 1'b1;
    @(posedge sys_clk);
    @(negedge sys_clk);
    if (bp) begin
      cmd_op = 2'd2;
      cmd_count = 6'd2;
    end else begin
      cmd_valid = 1'b0;
    end
    total = (op >= 2) ? n : 1;
    if (op >= 2)     d = (n == 0) ? 1 : n * PER;
    else if (op == 0) d = PER;
    else              d = PER + CAL_WAIT;
    for (int k = 1; k <= d; k++) begin
      slot = (total > 0) && ((k - 1) % PER == 0)
             && ((k - 1) / PER < total);
      can = 1'b1;
      if (op == 2) can = (mtap < TAP_MAX);
      if (op == 3) can = (mtap > 0);
      if (k == abort_at) begin
        sys_rst_n = 1'b0;
        cmd_valid = 1'b0;
        #1;
        mtap = 0;
        msat = 1'b0;
`ifdef HPDMC_DLY_SEQ_AUTOCAL_EN
        chk_idle_outs("abort", 1'b0);
`else
        chk_idle_outs("abort", 1'b1);
`endif
        repeat (4) @(negedge sys_clk);
        chk("abort_no_done", done, 0);
        chk("abort_no_ce", idelay_ce, 0);
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
        post_reset();
        return;
      end
      chk("ce", idelay_ce, slot && op >= 2 && can);
      chk("rst", idelay_rst, slot && op == 0);
      chk("cal", idelay_cal, slot && op == 1);
      chk("inc", idelay_inc, op == 2 && n > 0);
      chk("done", done, k == d);
      chk("busy_ready", cmd_ready, op >= 2 && n == 0);
      chk("tap", tap, mtap);
      chk("sat", sat, msat);
      if (slot) begin
        if (op == 0) begin
          mtap = 0;
          msat = 1'b0;
        end else if (op >= 2 && !can) begin
          msat = 1'b1;
        end else if (op == 2) begin
          mtap++;
        end else if (op == 3) begin
          mtap--;
        end
      end
      @(negedge sys_clk);
    end
    chk("end_ready", cmd_ready, 1);
    chk("end_done", done, 0);
    chk("end_tap", tap, mtap);
    chk("end_sat", sat, msat);
  endtask

  initial begin
    do_reset();

    run_cmd(2, 5, 1'b0, 0);
    chk("inc5_tap", tap, 5);

    repeat (8) run_cmd($urandom_range(2, 3), $urandom_range(0, 12),
                       1'b0, 0);

    run_cmd(0, $urandom_range(0, 63), 1'b0, 0);
    chk("rst_tap", tap, 0);

    repeat (5) run_cmd(2, 50, 1'b0, 0);
    chk("at250", tap, 250);
    run_cmd(2, 10, 1'b0, 0);
    chk("sat_tap", tap, 255);
    chk("sat_flag", sat, 1);
    run_cmd(3, 3, 1'b0, 0);
    chk("dec_tap", tap, 252);
    chk("dec_sat", sat, 1);
    run_cmd(0, 0, 1'b0, 0);
    chk("clr_tap", tap, 0);
    chk("clr_sat", sat, 0);

    run_cmd(2, 0, 1'b0, 0);
    run_cmd(2, 4, 1'b0, 0);
    run_cmd(3, 3, 1'b1, 0);
    run_cmd(2, 2, 1'b0, 0);
    chk("bp_tap", tap, 3);

    run_cmd(1, $urandom_range(0, 63), 1'b0, 0);

    repeat (6) run_cmd($urandom_range(0, 3), $urandom_range(0, 10),
                       1'b0, 0);

    run_cmd(2, 8, 1'b0, 13);
    run_cmd(2, 3, 1'b0, 0);
    chk("after_abort_tap", tap, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
